// File: rtl/rf_sb_unit_pkg.sv
// Shared constants for the register file / scoreboard unit.
package rf_sb_unit_pkg;

    localparam int unsigned REG_NUM        = 32;
    localparam int unsigned REG_ADDR_WIDTH = $clog2(REG_NUM);
    localparam int unsigned INST_REG_DATA  = 32;
    localparam int unsigned INST_REG_ADDR  = REG_ADDR_WIDTH;
    localparam int unsigned RD_PORTS_DEF   = 2;
    localparam int unsigned SP_IDX_DEF     = 2;

    localparam logic [INST_REG_DATA-1:0]  ZERO_WORD     = '0;
    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG_ADDR = '0;
    localparam logic [INST_REG_DATA-1:0]  SP_RST_VAL    = 32'h0000_00ff;

endpackage

// File: rtl/rf_sb_unit_if.sv
// Bus between the ID stage (master) and the register file / scoreboard (slave).
interface rf_sb_unit_if #(
    parameter int unsigned DATA_W   = rf_sb_unit_pkg::INST_REG_DATA,
    parameter int unsigned ADDR_W   = rf_sb_unit_pkg::INST_REG_ADDR,
    parameter int unsigned RD_PORTS = rf_sb_unit_pkg::RD_PORTS_DEF
);

    logic [RD_PORTS*ADDR_W-1:0] rd_addr;
    logic [RD_PORTS*DATA_W-1:0] rd_data;
    logic [RD_PORTS-1:0]        rd_rdy;
    logic [RD_PORTS-1:0]        rd_en;
    logic                       stall;
    logic                       iss_en;
    logic [ADDR_W-1:0]          iss_addr;
    logic                       wr0_en;
    logic [ADDR_W-1:0]          wr0_addr;
    logic [DATA_W-1:0]          wr0_data;
    logic                       wr1_en;
    logic [ADDR_W-1:0]          wr1_addr;
    logic [DATA_W-1:0]          wr1_data;
    logic [ADDR_W:0]            busy_cnt;

    modport master (
        output rd_addr, rd_en, iss_en, iss_addr,
        output wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
        input  rd_data, rd_rdy, stall, busy_cnt
    );

    modport slave (
        input  rd_addr, rd_en, iss_en, iss_addr,
        input  wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
        output rd_data, rd_rdy, stall, busy_cnt
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one bit per register owned by an outstanding late write.
module rf_scoreboard #(
    parameter int unsigned REG_NUM = rf_sb_unit_pkg::REG_NUM,
    parameter int unsigned ADDR_W  = $clog2(REG_NUM)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               iss_en_i,
    input  logic [ADDR_W-1:0]  iss_addr_i,
    input  logic               wr1_en_i,
    input  logic [ADDR_W-1:0]  wr1_addr_i,
    output logic [REG_NUM-1:0] busy_o,
    output logic [ADDR_W:0]    busy_cnt_o
);

    logic [REG_NUM-1:0] busy_d, busy_q;
    logic [ADDR_W:0]    cnt_d, cnt_q;

    // Next busy vector: clear on late write, then set on issue so a same-cycle set wins.
    always_comb begin
        busy_d = busy_q;
        if (wr1_en_i) begin
            busy_d[wr1_addr_i] = 1'b0;
        end
        if (iss_en_i && (iss_addr_i != '0)) begin
            busy_d[iss_addr_i] = 1'b1;
        end
    end

    // Count of busy registers after the update.
    always_comb begin
        cnt_d = '0;
        for (int unsigned i = 0; i < REG_NUM; i++) begin
            cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    // Busy state and its count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/rf_sb_unit.sv
// Register file with two write ports, bypassed read ports and operand-readiness tracking.
module rf_sb_unit #(
    parameter int unsigned       DATA_W   = rf_sb_unit_pkg::INST_REG_DATA,
    parameter int unsigned       REG_NUM  = rf_sb_unit_pkg::REG_NUM,
    parameter int unsigned       ADDR_W   = $clog2(REG_NUM),
    parameter int unsigned       RD_PORTS = rf_sb_unit_pkg::RD_PORTS_DEF,
    parameter int unsigned       SP_IDX   = rf_sb_unit_pkg::SP_IDX_DEF,
    parameter logic [DATA_W-1:0] SP_RST   = DATA_W'(rf_sb_unit_pkg::SP_RST_VAL)
) (
    input  logic         clk,
    input  logic         rst_n,
    rf_sb_unit_if.slave  bus
);

    logic [DATA_W-1:0]          regs_q [REG_NUM];
    logic [REG_NUM-1:0]         busy;
    logic [RD_PORTS*DATA_W-1:0] rd_data_w;
    logic [RD_PORTS-1:0]        rd_rdy_w;

    rf_scoreboard #(
        .REG_NUM (REG_NUM),
        .ADDR_W  (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .iss_en_i   (bus.iss_en),
        .iss_addr_i (bus.iss_addr),
        .wr1_en_i   (bus.wr1_en),
        .wr1_addr_i (bus.wr1_addr),
        .busy_o     (busy),
        .busy_cnt_o (bus.busy_cnt)
    );

    // Array update: wr0 carries the younger instruction, so it wins an address clash.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= (i == SP_IDX) ? SP_RST : '0;
            end
        end else begin
            for (int unsigned i = 1; i < REG_NUM; i++) begin
                if (bus.wr0_en && (bus.wr0_addr == ADDR_W'(i))) begin
                    regs_q[i] <= bus.wr0_data;
                end else if (bus.wr1_en && (bus.wr1_addr == ADDR_W'(i))) begin
                    regs_q[i] <= bus.wr1_data;
                end
            end
        end
    end

    for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              wr1_hit;

        assign addr    = bus.rd_addr[k*ADDR_W +: ADDR_W];
        assign wr1_hit = bus.wr1_en && (bus.wr1_addr == addr);

        // Read mux: x0, then wr0 bypass, then wr1 bypass, then array.
        always_comb begin
            data = regs_q[addr];
            if (addr == '0) begin
                data = '0;
            end else if (bus.wr0_en && (bus.wr0_addr == addr)) begin
                data = bus.wr0_data;
            end else if (wr1_hit) begin
                data = bus.wr1_data;
            end
        end

        assign rd_data_w[k*DATA_W +: DATA_W] = data;
        // A wr0 hit alone never frees a busy register: the late unit still owns it.
        assign rd_rdy_w[k] = (addr == '0) || !busy[addr] || wr1_hit;
    end

    assign bus.rd_data = rd_data_w;
    assign bus.rd_rdy  = rd_rdy_w;
    assign bus.stall   = |(bus.rd_en & ~rd_rdy_w);

endmodule

// File: tb/tb_rf_sb_unit.sv
// Scoreboard bench for rf_sb_unit: directed scenarios followed by random traffic.
module tb_rf_sb_unit;

    localparam int unsigned DW   = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned RP   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rf_sb_unit_if #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(RP)) bus ();

    rf_sb_unit #(
        .DATA_W   (DW),
        .REG_NUM  (NREG),
        .ADDR_W   (AW),
        .RD_PORTS (RP),
        .SP_IDX   (2),
        .SP_RST   (32'h0000_00ff)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [RP*DW-1:0] data;
        logic [RP-1:0]    rdy;
        logic             stall;
        logic [AW:0]      cnt;
    } exp_t;

    exp_t        expq[$];
    logic [DW-1:0] mregs [NREG];
    bit          mbusy [NREG];
    int          checks = 0;
    int          errors = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NREG; i++) begin
            mregs[i] = (i == 2) ? 32'h0000_00ff : 32'h0;
            mbusy[i] = 1'b0;
        end
    endfunction

    function automatic int model_busy_count();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += int'(mbusy[i]);
        return n;
    endfunction

    task automatic idle_inputs();
        bus.rd_en  = '0;
        bus.iss_en = 1'b0;
        bus.wr0_en = 1'b0;
        bus.wr1_en = 1'b0;
    endtask

    // One cycle of stimulus: drive, predict this cycle's outputs, then advance the model.
    task automatic step(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [1:0] re,
                        input logic ien, input logic [AW-1:0] ia,
                        input logic w0e, input logic [AW-1:0] w0a, input logic [DW-1:0] w0d,
                        input logic w1e, input logic [AW-1:0] w1a, input logic [DW-1:0] w1d);
        exp_t e;
        logic [AW-1:0] a;
        @(posedge clk);
        #1;
        bus.rd_addr  = {a1, a0};
        bus.rd_en    = re;
        bus.iss_en   = ien;
        bus.iss_addr = ia;
        bus.wr0_en   = w0e;
        bus.wr0_addr = w0a;
        bus.wr0_data = w0d;
        bus.wr1_en   = w1e;
        bus.wr1_addr = w1a;
        bus.wr1_data = w1d;
        e.stall = 1'b0;
        for (int k = 0; k < 2; k++) begin
            a = (k == 0) ? a0 : a1;
            if (a == 0) e.data[k*DW +: DW] = '0;
            else if (w0e && w0a == a) e.data[k*DW +: DW] = w0d;
            else if (w1e && w1a == a) e.data[k*DW +: DW] = w1d;
            else e.data[k*DW +: DW] = mregs[a];
            e.rdy[k] = (a == 0) || !mbusy[a] || (w1e && w1a == a);
            if (re[k] && !e.rdy[k]) e.stall = 1'b1;
        end
        e.cnt = (AW+1)'(model_busy_count());
        expq.push_back(e);
        if (w1e && w1a != 0) mregs[w1a] = w1d;
        if (w0e && w0a != 0) mregs[w0a] = w0d;
        if (w1e) mbusy[w1a] = 1'b0;
        if (ien && ia != 0) mbusy[ia] = 1'b1;
    endtask

    // Monitor: compares every presented cycle against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("rd_data", 64'(bus.rd_data), 64'(e.data));
                check("rd_rdy", 64'(bus.rd_rdy), 64'(e.rdy));
                check("stall", 64'(bus.stall), 64'(e.stall));
                check("busy_cnt", 64'(bus.busy_cnt), 64'(e.cnt));
            end
        end
    end

    initial begin
        bus.rd_addr  = '0;
        bus.iss_addr = '0;
        bus.wr0_addr = '0;
        bus.wr0_data = '0;
        bus.wr1_addr = '0;
        bus.wr1_data = '0;
        idle_inputs();
        model_reset();
        #12 rst_n = 1'b1;

        // Reset contents: SP holds its reset value, everything else zero.
        step(5'd2, 5'd5, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check("rst_data", 64'(bus.rd_data), {32'h0, 32'h0000_00ff});
        check("rst_rdy", 64'(bus.rd_rdy), 64'(2'b11));
        check("rst_cnt", 64'(bus.busy_cnt), 64'd0);

        // wr0 bypass, then array read.
        step(5'd0, 5'd7, 2'b10, 1'b0, 5'd0, 1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0, 32'h0);
        #1 check("wr0_bypass", 64'(bus.rd_data[63:32]), 64'h1234_5678);
        step(5'd7, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1 check("wr0_array", 64'(bus.rd_data[31:0]), 64'h1234_5678);

        // Issue x9, stall until the late write arrives.
        step(5'd0, 5'd0, 2'b00, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step(5'd9, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1 check("busy_stall", 64'(bus.stall), 64'd1);
        step(5'd9, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step(5'd9, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hDEAD_BEEF);
        #1;
        check("wr1_unstall", 64'(bus.stall), 64'd0);
        check("wr1_rdy", 64'(bus.rd_rdy[0]), 64'd1);
        check("wr1_data", 64'(bus.rd_data[31:0]), 64'hDEAD_BEEF);
        check("wr1_cnt_before", 64'(bus.busy_cnt), 64'd1);
        step(5'd9, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1 check("wr1_cnt_after", 64'(bus.busy_cnt), 64'd0);

        // wr0 and wr1 clash on x3: wr0 data wins, busy cleared.
        step(5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step(5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b1, 5'd3, 32'h0000_AAAA, 1'b1, 5'd3, 32'h0000_5555);
        step(5'd3, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check("clash_data", 64'(bus.rd_data[31:0]), 64'h0000_AAAA);
        check("clash_cnt", 64'(bus.busy_cnt), 64'd0);

        // Set and clear x4 together while busy: stays busy.
        step(5'd0, 5'd0, 2'b00, 1'b1, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step(5'd0, 5'd0, 2'b00, 1'b1, 5'd4, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h0000_0044);
        step(5'd4, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check("setwins_cnt", 64'(bus.busy_cnt), 64'd1);
        check("setwins_stall", 64'(bus.stall), 64'd1);
        step(5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h0000_0045);

        // x0 ignores issue and writes.
        step(5'd0, 5'd0, 2'b00, 1'b1, 5'd0, 1'b1, 5'd0, 32'h0000_FFFF, 1'b0, 5'd0, 32'h0);
        step(5'd0, 5'd0, 2'b11, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check("x0_data", 64'(bus.rd_data), 64'd0);
        check("x0_rdy", 64'(bus.rd_rdy), 64'(2'b11));
        check("x0_cnt", 64'(bus.busy_cnt), 64'd0);

        // Asynchronous reset in the middle of a stall.
        step(5'd0, 5'd0, 2'b00, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step(5'd9, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1 check("pre_rst_stall", 64'(bus.stall), 64'd1);
        #5;
        bus.iss_en = 1'b0;
        bus.wr0_en = 1'b0;
        bus.wr1_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rst_stall", 64'(bus.stall), 64'd0);
        check("async_rst_cnt", 64'(bus.busy_cnt), 64'd0);
        model_reset();
        #1 rst_n = 1'b1;
        step(5'd9, 5'd2, 2'b11, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Random traffic concentrated on a few registers to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] ra0, ra1, ia, w0a, w1a;
            ra0 = ($urandom % 4 == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            ra1 = ($urandom % 4 == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            ia  = AW'($urandom_range(0, 7));
            w0a = AW'($urandom_range(0, 7));
            w1a = AW'($urandom_range(0, 7));
            step(ra0, ra1, 2'($urandom_range(0, 3)),
                 ($urandom % 4 == 0), ia,
                 ($urandom % 2 == 0), w0a, $urandom,
                 ($urandom % 3 == 0), w1a, $urandom);
        end

        @(posedge clk);
        #1 idle_inputs();
        repeat (2) @(negedge clk);
        #1 check("queue_drained", 64'(expq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_sb_unit.md
Name: rf_sb_unit

Overview:
Parametrised general-purpose register file with N combinational read ports, two write ports and an integrated busy-bit scoreboard.
- Write port 0 is the in-order writeback path (ALU/CSR).
- Write port 1 is the late path for multi-cycle units (load, divider).
- The decode stage marks a destination busy at issue. The block reports per-port operand readiness and a single stall request.
- Drop-in replacement for the current two-read/one-write register file in the core's ID stage.

Parameters:
- DATA_W, 32, register width in bits
- REG_NUM, 32, number of registers; power of two, at least 2
- ADDR_W, $clog2(REG_NUM), register address width
- RD_PORTS, 2, number of read ports, 1..4
- SP_IDX, 2, index of the stack-pointer register
- SP_RST, 32'h0000_00ff, reset value of register SP_IDX

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  RD_PORTS*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  RD_PORTS*DATA_W  read data, same packing
- rd_rdy  out  RD_PORTS  operand k is valid this cycle
- stall  out  1  OR over k of rd_en[k] & ~rd_rdy[k]
- rd_en  in  RD_PORTS  port k is actually used by the instruction in ID
- iss_en  in  1  mark iss_addr busy; pulsed at issue of a late-writing instruction
- iss_addr  in  ADDR_W  destination of the issued late-writing instruction
- wr0_en  in  1  writeback-port write enable
- wr0_addr  in  ADDR_W  writeback-port address
- wr0_data  in  DATA_W  writeback-port data
- wr1_en  in  1  late-port write enable; clears the busy bit
- wr1_addr  in  ADDR_W  late-port address
- wr1_data  in  DATA_W  late-port data
- busy_cnt  out  ADDR_W+1  number of registers currently busy

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - All registers are 0, except register SP_IDX, which is SP_RST.
  - All busy bits are 0 and busy_cnt is 0.
  - rd_data follows the combinational rules below using the reset contents.
- Register x0: reads always return 0 with rd_rdy=1. Writes to x0 are ignored. iss_addr=0 never sets busy.
- Read priority, combinational, 0 cycles, evaluated per port:
  1. Address is 0: data 0.
  2. wr0_en and wr0_addr match: wr0_data.
  3. wr1_en and wr1_addr match: wr1_data.
  4. Otherwise the array contents.
- rd_rdy[k]:
  - 1 if the address is 0, or the busy bit is clear, or a wr1 write to that address occurs this cycle.
  - A wr0 hit on a busy register does NOT make it ready; the busy register is still owned by the late unit.
- Register writes, at the posedge of clk:
  - Both ports write the same non-zero address in one cycle: wr0 wins. wr0 carries the younger instruction.
  - Different addresses: both writes occur.
- Busy bits, at the posedge of clk:
  - set = iss_en & (iss_addr != 0); clear = wr1_en.
  - Set and clear on the same address in the same cycle: set wins. This covers back-to-back loads to the same rd.
  - iss_en on an already-busy register: the bit stays 1. Only one outstanding late write per register is supported.
  - wr1_en on a non-busy register: the data is written and the busy bit stays 0; this is not an error.
- busy_cnt: registered, equal to the popcount of the busy bits after the update. Each cycle it changes by -1, 0 or +1.
- stall: combinational. stall=0 whenever no port has rd_en asserted.
- Reset mid-operation: all state clears immediately. In-flight late writes that arrive after reset still write data but do not disturb the busy bits.

Decomposition:
- Shared constants go in defines.v: ZERO_WORD, ZERO_REG_ADDR, INST_REG_ADDR/INST_REG_DATA, REG_NUM, REG_ADDR_WIDTH. Add SP_RST_VAL there.
- Sub-module rf_scoreboard holds the busy bits and busy_cnt.
  - Inputs: iss_en, iss_addr, wr1_en, wr1_addr.
  - Outputs: busy vector and busy_cnt.
- rf_sb_unit owns the array, the bypass muxes (generate loop over RD_PORTS) and rd_rdy/stall.

Test Plan:
- Reset with default parameters, read x2 and x5 → rd_data 0x000000ff / 0; rd_rdy=2'b11; busy_cnt=0.
- wr0 x7←0x12345678; same cycle read x7 on port 1 → port 1 sees 0x12345678 combinationally; next cycle read from the array returns the same value.
- iss x9, then read x9 with rd_en=01 → stall=1 until a wr1 to x9 with 0xDEADBEEF. In that cycle rd_rdy[0]=1, data=0xDEADBEEF, stall=0; busy_cnt goes 1→0.
- Same cycle wr0 x3←0xAAAA and wr1 x3←0x5555 → x3 reads 0xAAAA afterwards; busy bit of x3 is cleared.
- iss x4 and wr1 x4 in the same cycle while x4 is busy → x4 remains busy; busy_cnt unchanged at 1.
- Writes and issue to x0 (iss x0, wr0 x0←0xFFFF) → x0 reads 0, rd_rdy=1, busy_cnt=0. Assert rst_n low mid-stall → stall drops and busy_cnt=0 asynchronously.
